// File: rtl/data_memory_lsu_if.sv
// Bus between the MEM stage and the data memory / load-store unit.
//   req, we, funct3, addr, wdata : access request (master -> slave)
//   rdata, ready, busy           : load result, completion pulse, in-flight flag
//   misaligned, access_fault     : error flags, valid with ready
interface data_memory_lsu_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        misaligned;
    logic        access_fault;

    modport master (
        output req, we, funct3, addr, wdata,
        input  rdata, ready, busy, misaligned, access_fault
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output rdata, ready, busy, misaligned, access_fault
    );
endinterface

// File: rtl/data_memory_lsu.sv
// Byte-addressable RV32I data memory with load/store unit (sb/sh/sw, lb/lh/lw/lbu/lhu).
// Ports:
//   clk  : clock, posedge
//   rst  : asynchronous active-high reset; aborts any access and reinitialises memory
//   bus  : data_memory_lsu_if.slave (req/we/funct3/addr/wdata in; rdata/ready/busy/flags out)
// An accepted access waits WAIT_CYCLES states, then completes in RESP with a one-cycle
// ready pulse. Alignment/range errors skip the wait and the memory access.
module data_memory_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    data_memory_lsu_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        l_we;
    logic [2:0]  l_f3;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, is_half, is_word, bad_f3, mis_c, flt_c, err_c;
    logic        enter_resp, do_mem;
    logic        op_we;
    logic [2:0]  op_f3;
    logic [31:0] op_addr, op_wdata;
    logic [AW-1:0] idx;
    logic [31:0] rword, wword, load_val;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        accept  = (state == IDLE) && bus.req;
        is_half = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);
        is_word = (bus.funct3 == 3'b010);
        bad_f3  = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
        mis_c   = (is_half && bus.addr[0]) || (is_word && (bus.addr[1:0] != 2'b00));
        flt_c   = ({1'b0, bus.addr} >= MEM_BYTES) || bad_f3;
        err_c   = mis_c || flt_c;

        // With zero wait states RESP is entered on the accept edge itself, so the
        // memory operation must come straight from the bus rather than the latches.
        op_we    = accept ? bus.we     : l_we;
        op_f3    = accept ? bus.funct3 : l_f3;
        op_addr  = accept ? bus.addr   : l_addr;
        op_wdata = accept ? bus.wdata  : l_wdata;

        enter_resp = (accept && (err_c || (WAIT_CYCLES == 0))) ||
                     ((state == WAIT) && (cnt == 4'd1));
        do_mem     = enter_resp && !(accept && err_c);

        idx   = op_addr[AW+1:2];
        rword = mem[idx];
        bsel  = rword[{op_addr[1:0], 3'b000} +: 8];
        hsel  = rword[{op_addr[1], 4'b0000} +: 16];

        // Read-modify-write merge of the store lanes into the current word.
        wword = rword;
        case (op_f3[1:0])
            2'b00:   wword[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
            2'b01:   wword[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
            default: wword = op_wdata;
        endcase

        case (op_f3)
            3'b000:  load_val = {{24{bsel[7]}}, bsel};
            3'b001:  load_val = {{16{hsel[15]}}, hsel};
            3'b100:  load_val = {24'h0, bsel};
            3'b101:  load_val = {16'h0, hsel};
            default: load_val = rword;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            l_we             <= 1'b0;
            l_f3             <= 3'b000;
            l_addr           <= 32'h0;
            l_wdata          <= 32'h0;
            bus.rdata        <= 32'h0;
            bus.ready        <= 1'b0;
            bus.busy         <= 1'b0;
            bus.misaligned   <= 1'b0;
            bus.access_fault <= 1'b0;
        end else begin
            bus.ready <= enter_resp;
            case (state)
                IDLE: if (bus.req) begin
                    l_we             <= bus.we;
                    l_f3             <= bus.funct3;
                    l_addr           <= bus.addr;
                    l_wdata          <= bus.wdata;
                    cnt              <= 4'(WAIT_CYCLES);
                    bus.misaligned   <= mis_c;
                    bus.access_fault <= flt_c;
                    bus.busy         <= 1'b1;
                    state            <= (err_c || (WAIT_CYCLES == 0)) ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                if (!do_mem)     bus.rdata <= 32'h0;
                else if (!op_we) bus.rdata <= load_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= (i == 1) ? 32'h0000_2222 : (i == 2) ? 32'h0000_7777 : 32'h0;
        end else if (do_mem && op_we) begin
            mem[idx] <= wword;
        end
    end
endmodule

// File: tb/tb_data_memory_lsu.sv
module tb_data_memory_lsu;
    localparam int DEPTH = 256;
    localparam int WC    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_lsu_if bus();
    data_memory_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Reference: flat byte array and the last expected load result.
    logic [7:0]  ref_mem [4*DEPTH];
    logic [31:0] exp_rdata;

    typedef struct packed {
        logic w; logic [2:0] f3; logic [31:0] a; logic [31:0] wd;
        logic [31:0] er; logic em; logic ef;
    } dir_t;
    dir_t tbl [16];

    task automatic model_reset();
        for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
        ref_mem[4] = 8'h22; ref_mem[5] = 8'h22;
        ref_mem[8] = 8'h77; ref_mem[9] = 8'h77;
        exp_rdata = 32'h0;
    endtask

    task automatic model_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic mis, output logic flt,
                                output int lat);
        int n;
        logic [31:0] v;
        mis = (((f3 == 3'd1) || (f3 == 3'd5)) && a[0]) || ((f3 == 3'd2) && (a[1:0] != 2'b00));
        flt = (a >= 32'(4*DEPTH)) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        lat = (mis || flt) ? 1 : WC + 1;
        if (mis || flt) begin
            exp_rdata = 32'h0;
            return;
        end
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (w) begin
            for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = v | (32'(ref_mem[int'(a) + k]) << (8*k));
            if (!f3[2] && (n < 4) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            exp_rdata = v;
        end
    endtask

    // Drives one access and reports what the DUT did; comparisons live in the tests.
    task automatic run_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output int lat, output logic bsy,
                              output logic once, output logic [31:0] rd,
                              output logic mis, output logic flt);
        int n;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        bus.req = 1'b0;
        bsy = bus.busy;
        n = 0;
        while (!bus.ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        lat = bus.ready ? n + 1 : -1;
        rd  = bus.rdata;
        mis = bus.misaligned;
        flt = bus.access_fault;
        @(posedge clk); #1;
        once = !bus.ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if ({bus.misaligned, bus.access_fault} !== 2'b00) begin errors++;
            $display("FAIL reset_flags got=%b%b exp=00", bus.misaligned, bus.access_fault); end
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        checks++; if ({bus.ready, bus.busy} !== 2'b00) begin errors++;
            $display("FAIL idle_after_reset ready/busy got=%b%b exp=00", bus.ready, bus.busy); end
    endtask

    task automatic test_directed();
        int lat, elat;
        logic bsy, once, mis, flt, em, ef;
        logic [31:0] rd;
        tbl[0]  = '{1'b0, 3'b010, 32'h04,  32'h0,        32'h0000_2222, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'b010, 32'h80,  32'hDEAD_BEEF, 32'h0000_2222, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'b000, 32'h83,  32'h0,        32'hFFFF_FFDE, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 3'b100, 32'h80,  32'h0,        32'h0000_00EF, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'b001, 32'h82,  32'h0,        32'hFFFF_DEAD, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 3'b000, 32'h81,  32'h55,       32'hFFFF_DEAD, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 3'b010, 32'h80,  32'h0,        32'hDEAD_55EF, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 3'b001, 32'h82,  32'h1234,     32'hDEAD_55EF, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 3'b010, 32'h80,  32'h0,        32'h1234_55EF, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 3'b101, 32'h82,  32'h0,        32'h0000_1234, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'b010, 32'h06,  32'h0,        32'h0,         1'b1, 1'b0};
        tbl[11] = '{1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b1};
        tbl[12] = '{1'b0, 3'b010, 32'h00,  32'h0,        32'h0,         1'b0, 1'b0};
        tbl[13] = '{1'b0, 3'b010, 32'h80,  32'h0,        32'h1234_55EF, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 3'b001, 32'h401, 32'h0,        32'h0,         1'b1, 1'b1};
        tbl[15] = '{1'b0, 3'b010, 32'h08,  32'h0,        32'h0000_7777, 1'b0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            model_access(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, em, ef, elat);
            run_access(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, lat, bsy, once, rd, mis, flt);
            checks++; if (lat !== elat) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, elat); end
            checks++; if (rd !== tbl[i].er) begin errors++; $display("FAIL dir%0d_rdata got=%h exp=%h", i, rd, tbl[i].er); end
            checks++; if (mis !== tbl[i].em) begin errors++; $display("FAIL dir%0d_misaligned got=%b exp=%b", i, mis, tbl[i].em); end
            checks++; if (flt !== tbl[i].ef) begin errors++; $display("FAIL dir%0d_fault got=%b exp=%b", i, flt, tbl[i].ef); end
            checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got=%b exp=1", i, bsy); end
            checks++; if (once !== 1'b1) begin errors++; $display("FAIL dir%0d_ready_pulse got=%b exp=1", i, once); end
        end
    endtask

    task automatic test_random();
        int lat, elat;
        logic bsy, once, mis, flt, em, ef, w;
        logic [2:0] f3;
        logic [31:0] a, wd, rd;
        logic [2:0] sf3 [5];
        logic [2:0] lf3 [7];
        sf3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
        lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};
        for (int i = 0; i < 80; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = w ? sf3[$urandom_range(0, 4)] : lf3[$urandom_range(0, 6)];
            case ($urandom_range(0, 7))
                0:       a = $urandom;
                1:       a = 32'h3F8 + 32'($urandom_range(0, 15));
                default: a = 32'($urandom_range(0, 63));
            endcase
            wd = $urandom;
            model_access(w, f3, a, wd, em, ef, elat);
            run_access(w, f3, a, wd, lat, bsy, once, rd, mis, flt);
            checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, elat); end
            checks++; if (rd !== exp_rdata) begin errors++;
                $display("FAIL rnd%0d_rdata we=%b f3=%0d a=%h got=%h exp=%h", i, w, f3, a, rd, exp_rdata); end
            checks++; if (mis !== em) begin errors++; $display("FAIL rnd%0d_misaligned got=%b exp=%b", i, mis, em); end
            checks++; if (flt !== ef) begin errors++; $display("FAIL rnd%0d_fault got=%b exp=%b", i, flt, ef); end
            checks++; if (once !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready_pulse got=%b exp=1", i, once); end
        end
    endtask

    task automatic test_busy_ignore();
        int nrdy, lat, elat;
        logic em, ef, bsy, once, mis, flt;
        logic [31:0] rd, last;
        model_access(1'b0, 3'b010, 32'h08, 32'h0, em, ef, elat);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h08;
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h0C; bus.wdata = 32'h5A5A_A5A5;
        @(negedge clk);
        bus.req = 1'b0;
        nrdy = 0; last = 32'h0;
        for (int c = 0; c < 2*WC + 8; c++) begin
            @(posedge clk); #1;
            if (bus.ready) begin nrdy++; last = bus.rdata; end
        end
        checks++; if (nrdy !== 1) begin errors++; $display("FAIL busy_ignore_readies got=%0d exp=1", nrdy); end
        checks++; if (last !== exp_rdata) begin errors++; $display("FAIL busy_ignore_rdata got=%h exp=%h", last, exp_rdata); end
        model_access(1'b0, 3'b010, 32'h0C, 32'h0, em, ef, elat);
        run_access(1'b0, 3'b010, 32'h0C, 32'h0, lat, bsy, once, rd, mis, flt);
        checks++; if (rd !== exp_rdata) begin errors++; $display("FAIL busy_ignore_no_store got=%h exp=%h", rd, exp_rdata); end
    endtask

    task automatic test_back_to_back();
        int t, got, extra, elat;
        int tm [3];
        logic [31:0] rds [3];
        logic em, ef;
        model_access(1'b0, 3'b001, 32'h82, 32'h0, em, ef, elat);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b001; bus.addr = 32'h82;
        t = 0; got = 0;
        while (got < 3 && t < 60) begin
            @(posedge clk); #1;
            t++;
            if (bus.ready) begin
                tm[got] = t; rds[got] = bus.rdata; got++;
                if (got == 3) bus.req = 1'b0;
            end
        end
        bus.req = 1'b0;
        checks++; if (got !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3 (timeout)", got); end
        if (got == 3) begin
            checks++; if (tm[0] !== WC + 1) begin errors++; $display("FAIL b2b_first got=%0d exp=%0d", tm[0], WC + 1); end
            checks++; if (tm[1] - tm[0] !== WC + 2) begin errors++; $display("FAIL b2b_gap1 got=%0d exp=%0d", tm[1] - tm[0], WC + 2); end
            checks++; if (tm[2] - tm[1] !== WC + 2) begin errors++; $display("FAIL b2b_gap2 got=%0d exp=%0d", tm[2] - tm[1], WC + 2); end
            for (int k = 0; k < 3; k++) begin
                checks++; if (rds[k] !== exp_rdata) begin errors++; $display("FAIL b2b_rdata%0d got=%h exp=%h", k, rds[k], exp_rdata); end
            end
        end
        extra = 0;
        for (int c = 0; c < 2*WC + 6; c++) begin
            @(posedge clk); #1;
            if (bus.ready) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_after_release got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        int lat, elat;
        logic bsy, once, mis, flt, em, ef;
        logic [31:0] rd;
        model_access(1'b0, 3'b010, 32'h80, 32'h0, em, ef, elat);
        run_access(1'b0, 3'b010, 32'h80, 32'h0, lat, bsy, once, rd, mis, flt);
        checks++; if (rd !== exp_rdata) begin errors++; $display("FAIL pre_reset_rdata got=%h exp=%h", rd, exp_rdata); end
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h10; bus.wdata = 32'h0000_AAAA;
        @(posedge clk); #1;
        bus.req = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata got=%h exp=0", bus.rdata); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", bus.ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        checks++; if ({bus.misaligned, bus.access_fault} !== 2'b00) begin errors++;
            $display("FAIL midrst_flags got=%b%b exp=00", bus.misaligned, bus.access_fault); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_access(1'b0, 3'b010, 32'h10, 32'h0, lat, bsy, once, rd, mis, flt);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midrst_store_dropped got=%h exp=0", rd); end
        run_access(1'b0, 3'b010, 32'h80, 32'h0, lat, bsy, once, rd, mis, flt);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midrst_mem_reinit got=%h exp=0", rd); end
        run_access(1'b0, 3'b010, 32'h04, 32'h0, lat, bsy, once, rd, mis, flt);
        checks++; if (rd !== 32'h0000_2222) begin errors++; $display("FAIL midrst_word1 got=%h exp=00002222", rd); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
